// File: rtl/cpu6502_pkg.sv
// Shared types for the 6502 decode/assemble stage: addressing modes,
// assembler FSM states, the decoded-instruction record and mode-to-size helper.
package cpu6502_pkg;

    typedef enum logic [3:0] {
        MODE_IMP  = 4'd0,
        MODE_ACC  = 4'd1,
        MODE_IMM  = 4'd2,
        MODE_ZP   = 4'd3,
        MODE_ZPX  = 4'd4,
        MODE_ZPY  = 4'd5,
        MODE_ABS  = 4'd6,
        MODE_ABSX = 4'd7,
        MODE_ABSY = 4'd8,
        MODE_IND  = 4'd9,
        MODE_INDX = 4'd10,
        MODE_INDY = 4'd11,
        MODE_REL  = 4'd12
    } mode_e;

    typedef enum logic [1:0] {
        ST_OPC,
        ST_OPR_LO,
        ST_OPR_HI
    } state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] operand;
        logic [15:0] pc;
        logic [1:0]  size;
        mode_e       mode;
        logic        illegal;
    } instr_t;

    localparam logic [7:0] NOP_OPCODE = 8'hEA;

    // Instruction length in bytes (opcode included) for an addressing mode.
    function automatic logic [1:0] mode_size(input mode_e mode);
        case (mode)
            MODE_IMP, MODE_ACC:                       mode_size = 2'd1;
            MODE_ABS, MODE_ABSX, MODE_ABSY, MODE_IND: mode_size = 2'd3;
            default:                                  mode_size = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/cpu6502_opcode_rom.sv
// Combinational opcode map: addressing mode and undocumented flag for all 256 opcodes.
module cpu6502_opcode_rom
    import cpu6502_pkg::*;
(
    input  logic [7:0] opcode,
    output mode_e      mode,
    output logic       illegal
);

    // Look up the 151 documented opcodes; everything else is undocumented and treated as IMP.
    always_comb begin
        // NOTE: both outputs get a value before the case, so no path through it can infer a latch.
        mode    = MODE_IMP;
        illegal = 1'b0;
        case (opcode)
            8'h00, 8'h08, 8'h18, 8'h28, 8'h38, 8'h40, 8'h48, 8'h58, 8'h60,
            8'h68, 8'h78, 8'h88, 8'h8A, 8'h98, 8'h9A, 8'hA8, 8'hAA, 8'hB8,
            8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA, 8'hF8:
                mode = MODE_IMP;
            8'h0A, 8'h2A, 8'h4A, 8'h6A:
                mode = MODE_ACC;
            8'h09, 8'h29, 8'h49, 8'h69, 8'hA9, 8'hC9, 8'hE9,
            8'hA0, 8'hA2, 8'hC0, 8'hE0:
                mode = MODE_IMM;
            8'h05, 8'h25, 8'h45, 8'h65, 8'h85, 8'hA5, 8'hC5, 8'hE5,
            8'h06, 8'h26, 8'h46, 8'h66, 8'h86, 8'hA6, 8'hC6, 8'hE6,
            8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4:
                mode = MODE_ZP;
            8'h15, 8'h35, 8'h55, 8'h75, 8'h95, 8'hB5, 8'hD5, 8'hF5,
            8'h16, 8'h36, 8'h56, 8'h76, 8'hD6, 8'hF6, 8'h94, 8'hB4:
                mode = MODE_ZPX;
            8'h96, 8'hB6:
                mode = MODE_ZPY;
            8'h0D, 8'h2D, 8'h4D, 8'h6D, 8'h8D, 8'hAD, 8'hCD, 8'hED,
            8'h0E, 8'h2E, 8'h4E, 8'h6E, 8'h8E, 8'hAE, 8'hCE, 8'hEE,
            8'h2C, 8'h8C, 8'hAC, 8'hCC, 8'hEC, 8'h4C, 8'h20:
                mode = MODE_ABS;
            8'h1D, 8'h3D, 8'h5D, 8'h7D, 8'h9D, 8'hBD, 8'hDD, 8'hFD,
            8'h1E, 8'h3E, 8'h5E, 8'h7E, 8'hDE, 8'hFE, 8'hBC:
                mode = MODE_ABSX;
            8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hD9, 8'hF9, 8'hBE:
                mode = MODE_ABSY;
            8'h6C:
                mode = MODE_IND;
            8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1:
                mode = MODE_INDX;
            8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1, 8'hF1:
                mode = MODE_INDY;
            8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
                mode = MODE_REL;
            default:
                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu6502_decode_assembler.sv
// Gathers the fetch byte stream into whole 6502 instructions (opcode + 0..2
// operand bytes) and queues them in a small FIFO for the execute stage.
module cpu6502_decode_assembler
    import cpu6502_pkg::*;
#(
    parameter int OUT_DEPTH      = 2,
    parameter bit ILLEGAL_AS_NOP = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic [15:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_opcode,
    output logic [15:0] out_operand,
    output logic [15:0] out_pc,
    output logic [1:0]  out_size,
    output logic [3:0]  out_mode,
    output logic        out_illegal
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUT_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUT_DEPTH);

    state_e           state_q, state_d;
    logic [7:0]       opc_q;
    logic [15:0]      pc_q;
    logic [7:0]       lo_q;

    logic [7:0]       rom_opcode;
    mode_e            rom_mode;
    logic             rom_illegal;
    logic [1:0]       cur_size;

    logic             accept, push, pop;
    instr_t           push_entry;
    instr_t           mem [OUT_DEPTH];
    instr_t           head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full, fifo_empty;

    // In OPC the incoming byte is the opcode; afterwards the latched opcode drives the decode.
    assign rom_opcode = (state_q == ST_OPC) ? in_byte : opc_q;

    cpu6502_opcode_rom u_rom (
        .opcode  (rom_opcode),
        .mode    (rom_mode),
        .illegal (rom_illegal)
    );

    assign cur_size   = mode_size(rom_mode);
    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign in_ready   = !rst && !fifo_full && !flush;
    assign accept     = in_valid && in_ready;
    assign out_valid  = !rst && !fifo_empty;
    assign pop        = out_valid && out_ready;

    // Next-state logic and assembly of the instruction completed by this byte.
    always_comb begin
        state_d            = state_q;
        push               = 1'b0;
        push_entry.opcode  = (rom_illegal && ILLEGAL_AS_NOP) ? NOP_OPCODE : rom_opcode;
        push_entry.operand = 16'h0000;
        push_entry.pc      = (state_q == ST_OPC) ? in_pc : pc_q;
        push_entry.size    = cur_size;
        push_entry.mode    = rom_mode;
        push_entry.illegal = rom_illegal;
        case (state_q)
            ST_OPC: begin
                if (accept) begin
                    if (cur_size == 2'd1) push = 1'b1;
                    else                  state_d = ST_OPR_LO;
                end
            end
            ST_OPR_LO: begin
                push_entry.operand = {8'h00, in_byte};
                if (accept) begin
                    if (cur_size == 2'd2) begin
                        push    = 1'b1;
                        state_d = ST_OPC;
                    end else begin
                        state_d = ST_OPR_HI;
                    end
                end
            end
            ST_OPR_HI: begin
                push_entry.operand = {in_byte, lo_q};
                if (accept) begin
                    push    = 1'b1;
                    state_d = ST_OPC;
                end
            end
            default: state_d = ST_OPC;
        endcase
    end

    // FSM state register; reset and flush both restart at an opcode boundary.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || flush) state_q <= ST_OPC;
        else              state_q <= state_d;
    end

    // Hold the opcode, its address and the low operand byte while the instruction is incomplete.
    always_ff @(posedge clk) begin
        if (accept && state_q == ST_OPC) begin
            opc_q <= in_byte;
            pc_q  <= in_pc;
        end
        if (accept && state_q == ST_OPR_LO) lo_q <= in_byte;
    end

    // FIFO storage: write completed instructions at the tail.
    always_ff @(posedge clk) begin
        // NOTE: the entries are not reset; count gates visibility, so stale contents are never presented.
        if (push) mem[wr_ptr] <= push_entry;
    end

    // FIFO pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry drives the outputs; fields read as zero whenever nothing is valid.
    assign head        = mem[rd_ptr];
    assign out_opcode  = out_valid ? head.opcode  : 8'h00;
    assign out_operand = out_valid ? head.operand : 16'h0000;
    assign out_pc      = out_valid ? head.pc      : 16'h0000;
    assign out_size    = out_valid ? head.size    : 2'd0;
    assign out_mode    = out_valid ? head.mode    : 4'd0;
    assign out_illegal = out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_cpu6502_decode_assembler.sv
// Directed bench for the decode assembler. Two copies share one stimulus stream:
// dut_a keeps illegal opcodes, dut_b replaces them with EA. Expected instructions
// go into per-DUT queues; monitors pop and compare whenever an output is taken.
`timescale 1ns/1ps
module tb_cpu6502_decode_assembler;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] operand;
        logic [15:0] pc;
        logic [1:0]  size;
        logic [3:0]  mode;
        logic        illegal;
    } exp_t;

    typedef struct packed {
        logic [7:0]  b0, b1, b2;
        logic [1:0]  n;
        logic [15:0] opr;
        logic [1:0]  size;
        logic [3:0]  mode;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [7:0]  in_byte;
    logic [15:0] in_pc;

    logic        a_in_ready, a_out_valid, a_ill;
    logic [7:0]  a_op;
    logic [15:0] a_opr, a_pc;
    logic [1:0]  a_size;
    logic [3:0]  a_mode;

    logic        b_in_ready, b_out_valid, b_ill;
    logic [7:0]  b_op;
    logic [15:0] b_opr, b_pc;
    logic [1:0]  b_size;
    logic [3:0]  b_mode;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t got_a, got_b, exp_a, exp_b;

    int tests  = 0;
    int failed = 0;

    cpu6502_decode_assembler #(.OUT_DEPTH(2), .ILLEGAL_AS_NOP(1'b0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_byte(in_byte), .in_pc(in_pc),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_opcode(a_op), .out_operand(a_opr), .out_pc(a_pc),
        .out_size(a_size), .out_mode(a_mode), .out_illegal(a_ill)
    );

    cpu6502_decode_assembler #(.OUT_DEPTH(2), .ILLEGAL_AS_NOP(1'b1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_byte(in_byte), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_opcode(b_op), .out_operand(b_opr), .out_pc(b_pc),
        .out_size(b_size), .out_mode(b_mode), .out_illegal(b_ill)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_instr(input string name, input exp_t got, input exp_t exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got op=%h opr=%h pc=%h size=%0d mode=%0d ill=%b, expected op=%h opr=%h pc=%h size=%0d mode=%0d ill=%b",
                     name, got.opcode, got.operand, got.pc, got.size, got.mode, got.illegal,
                     exp.opcode, exp.operand, exp.pc, exp.size, exp.mode, exp.illegal);
        end
    endtask

    // dut_a monitor: every taken output must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && a_out_valid && out_ready) begin
            got_a = '{a_op, a_opr, a_pc, a_size, a_mode, a_ill};
            if (q_a.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL a_unexpected: got op=%h pc=%h, expected no output", a_op, a_pc);
            end else begin
                exp_a = q_a.pop_front();
                check_instr("a_out", got_a, exp_a);
            end
        end
    end

    // dut_b monitor.
    always @(negedge clk) begin
        if (!rst && b_out_valid && out_ready) begin
            got_b = '{b_op, b_opr, b_pc, b_size, b_mode, b_ill};
            if (q_b.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL b_unexpected: got op=%h pc=%h, expected no output", b_op, b_pc);
            end else begin
                exp_b = q_b.pop_front();
                check_instr("b_out", got_b, exp_b);
            end
        end
    end

    task automatic expect_instr(input logic [7:0] op, input logic [15:0] opr, input logic [15:0] pc,
                                input logic [1:0] size, input logic [3:0] mode, input logic ill);
        q_a.push_back('{op, opr, pc, size, mode, ill});
        q_b.push_back('{(ill ? 8'hEA : op), opr, pc, size, mode, ill});
    endtask

    task automatic drive(input logic [7:0] b, input logic [15:0] pc);
        in_valid = 1'b1;
        in_byte  = b;
        in_pc    = pc;
    endtask

    // Wait for the driven byte to be taken; reports out_valid seen in the accepting cycle.
    task automatic wait_accept(output logic pre_valid);
        int n;
        n = 0;
        pre_valid = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            if (a_in_ready) break;
            n++;
        end
        if (n >= 50) begin
            tests++;
            failed++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
        end
        pre_valid = a_out_valid;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic [15:0] pc);
        logic dummy;
        drive(b, pc);
        wait_accept(dummy);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d/%0d outputs outstanding, expected 0", q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    initial begin
        vec_t        vecs[$];
        logic        pre;
        logic [15:0] pc;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_byte   = 8'hA9;
        in_pc     = 16'h0000;
        out_ready = 1'b1;

        // Reset state with a byte presented.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", a_in_ready, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_fields", {a_op, a_opr, a_pc, a_size, a_mode, a_ill}, 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;

        // LDA #$42 and JMP $1234 with the output latency check.
        expect_instr(8'hA9, 16'h0042, 16'h8000, 2'd2, 4'd2, 1'b0);
        send(8'hA9, 16'h8000);
        send(8'h42, 16'h8001);
        expect_instr(8'h4C, 16'h1234, 16'h8002, 2'd3, 4'd6, 1'b0);
        send(8'h4C, 16'h8002);
        send(8'h34, 16'h8003);
        drive(8'h12, 16'h8004);
        wait_accept(pre);
        check("lat_before", pre, 0);
        check("lat_after", a_out_valid, 1);
        drain();

        // One instruction per addressing mode, plus undocumented opcodes.
        vecs.push_back('{8'h0A, 8'h00, 8'h00, 2'd1, 16'h0000, 2'd1, 4'd1,  1'b0});
        vecs.push_back('{8'hA5, 8'h10, 8'h00, 2'd2, 16'h0010, 2'd2, 4'd3,  1'b0});
        vecs.push_back('{8'hB4, 8'h20, 8'h00, 2'd2, 16'h0020, 2'd2, 4'd4,  1'b0});
        vecs.push_back('{8'h96, 8'h30, 8'h00, 2'd2, 16'h0030, 2'd2, 4'd5,  1'b0});
        vecs.push_back('{8'hBD, 8'h00, 8'h20, 2'd3, 16'h2000, 2'd3, 4'd7,  1'b0});
        vecs.push_back('{8'h99, 8'hCD, 8'hAB, 2'd3, 16'hABCD, 2'd3, 4'd8,  1'b0});
        vecs.push_back('{8'h6C, 8'hFC, 8'hFF, 2'd3, 16'hFFFC, 2'd3, 4'd9,  1'b0});
        vecs.push_back('{8'h81, 8'h44, 8'h00, 2'd2, 16'h0044, 2'd2, 4'd10, 1'b0});
        vecs.push_back('{8'hB1, 8'h55, 8'h00, 2'd2, 16'h0055, 2'd2, 4'd11, 1'b0});
        vecs.push_back('{8'hD0, 8'hFE, 8'h00, 2'd2, 16'h00FE, 2'd2, 4'd12, 1'b0});
        vecs.push_back('{8'h60, 8'h00, 8'h00, 2'd1, 16'h0000, 2'd1, 4'd0,  1'b0});
        vecs.push_back('{8'h02, 8'h00, 8'h00, 2'd1, 16'h0000, 2'd1, 4'd0,  1'b1});
        vecs.push_back('{8'h8B, 8'h00, 8'h00, 2'd1, 16'h0000, 2'd1, 4'd0,  1'b1});
        vecs.push_back('{8'h9C, 8'h00, 8'h00, 2'd1, 16'h0000, 2'd1, 4'd0,  1'b1});
        vecs.push_back('{8'hFF, 8'h00, 8'h00, 2'd1, 16'h0000, 2'd1, 4'd0,  1'b1});
        pc = 16'hA000;
        foreach (vecs[i]) begin
            expect_instr(vecs[i].b0, vecs[i].opr, pc, vecs[i].size, vecs[i].mode, vecs[i].ill);
            send(vecs[i].b0, pc);
            if (vecs[i].n > 2'd1) send(vecs[i].b1, pc + 16'd1);
            if (vecs[i].n > 2'd2) send(vecs[i].b2, pc + 16'd2);
            pc = pc + 16'(vecs[i].n);
        end
        drain();

        // Backpressure: two EAs fill the FIFO, third waits until out_ready rises.
        out_ready = 1'b0;
        expect_instr(8'hEA, 16'h0000, 16'h9000, 2'd1, 4'd0, 1'b0);
        expect_instr(8'hEA, 16'h0000, 16'h9001, 2'd1, 4'd0, 1'b0);
        expect_instr(8'hEA, 16'h0000, 16'h9002, 2'd1, 4'd0, 1'b0);
        send(8'hEA, 16'h9000);
        send(8'hEA, 16'h9001);
        @(negedge clk);
        check("full_in_ready", a_in_ready, 0);
        @(posedge clk); #1;
        drive(8'hEA, 16'h9002);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_hold_ready", a_in_ready, 0);
            check("full_hold_head", {a_out_valid, a_pc}, {1'b1, 16'h9000});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept(pre);
        drain();

        // Flush mid-JSR with a queued instruction and a byte presented during flush.
        out_ready = 1'b0;
        send(8'hEA, 16'h7000);
        send(8'h20, 16'h7001);
        send(8'h00, 16'h7002);
        @(negedge clk);
        check("pre_flush_valid", a_out_valid, 1);
        @(posedge clk); #1;
        flush = 1'b1;
        drive(8'h34, 16'h7003);
        @(negedge clk);
        check("flush_in_ready", a_in_ready, 0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_valid_a", a_out_valid, 0);
        check("post_flush_valid_b", b_out_valid, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        expect_instr(8'hA9, 16'h0001, 16'h7010, 2'd2, 4'd2, 1'b0);
        send(8'hA9, 16'h7010);
        send(8'h01, 16'h7011);
        drain();

        // Reset mid-instruction: next byte must be decoded as an opcode.
        send(8'hAD, 16'h6000);
        send(8'h00, 16'h6001);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", a_in_ready, 0);
        check("midrst_out_valid", a_out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        expect_instr(8'hE8, 16'h0000, 16'h6010, 2'd1, 4'd0, 1'b0);
        send(8'hE8, 16'h6010);
        drain();

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
